// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between the MW stage and a variable-latency
// data memory. Builds byte masks and lane-aligned store data, extracts and
// extends load data, stalls the pipeline while the memory is busy, and
// reports misaligned, illegal-size and timed-out accesses as mcause faults.
module lsu_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                is_store,
  input  logic [2:0]          funct3,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                fault,
  output logic [3:0]          fault_cause,
  output logic [ADDR_W-1:0]   fault_addr,
  output logic                mem_cs,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  // Byte enables for an access of 2**sz bytes starting at lane offset off.
  function automatic logic [NB-1:0] f_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic [NB-1:0] m;
    case (sz)
      2'd0:    m = NB'(1) << off;
      2'd1:    m = NB'(3) << off;
      2'd2:    m = NB'(15) << off;
      default: m = '1;
    endcase
    return m;
  endfunction

  // Replicate the store operand across every lane so the mask alone selects it.
  function automatic logic [DATA_W-1:0] f_align(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    case (sz)
      2'd0:    r = {NB{d[7:0]}};
      2'd1:    r = {(NB/2){d[15:0]}};
      2'd2:    r = {(NB/4){d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Sign- or zero-extend the low lane bytes according to the load funct3.
  function automatic logic [DATA_W-1:0] f_extend(input logic [2:0] f3, input logic [DATA_W-1:0] lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [DATA_W-1:0]  r;
    b = lane[7:0];
    h = lane[15:0];
    w = lane[31:0];
    case (f3)
      3'b000:  r = DATA_W'(b);
      3'b001:  r = DATA_W'(h);
      3'b010:  r = DATA_W'(w);
      3'b100:  r = DATA_W'(lane[7:0]);
      3'b101:  r = DATA_W'(lane[15:0]);
      3'b110:  r = DATA_W'(lane[31:0]);
      default: r = lane;
    endcase
    return r;
  endfunction

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_store;
  logic [2:0]          r_f3;
  logic [NB-1:0]       r_mask;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_fault;

  logic [1:0]          w_sz;
  logic                w_illegal;
  logic                w_misal;
  logic                w_take;
  logic                w_imm_fault;
  logic                w_accept;
  logic                w_resp_fault;
  logic [3:0]          w_imm_cause;
  logic [DATA_W-1:0]   w_lane;

  assign w_sz = funct3[1:0];

  // Request classification in IDLE: illegal size, misalignment, acceptance.
  always_comb begin
    w_illegal = (funct3 == 3'b111) ||
                ((DATA_W == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
    case (w_sz)
      2'd0:    w_misal = 1'b0;
      2'd1:    w_misal = addr[0];
      2'd2:    w_misal = |addr[1:0];
      default: w_misal = |addr[2:0];
    endcase
    w_take      = (r_state == S_IDLE) && req_valid && !rst;
    w_imm_fault = w_take && (w_illegal || w_misal);
    w_accept    = w_take && !(w_illegal || w_misal);
  end

  // mcause: 4/5 load misaligned/access fault, 6/7 store equivalents.
  assign w_imm_cause  = {2'b01, is_store, w_illegal};
  assign w_resp_fault = (r_state == S_RESP) && r_fault;
  assign w_lane       = mem_rdata >> {r_addr[OFF_W-1:0], 3'b000};

  assign stall       = w_accept || (r_state == S_ACCESS);
  assign done        = w_imm_fault || (r_state == S_RESP);
  assign fault       = w_imm_fault || w_resp_fault;
  assign fault_cause = w_imm_fault ? w_imm_cause : (w_resp_fault ? {2'b01, r_store, 1'b1} : 4'd0);
  assign fault_addr  = w_imm_fault ? addr : r_addr;
  assign rdata       = r_rdata;
  assign mem_cs      = (r_state == S_ACCESS);
  assign mem_wr      = mem_cs && r_store;
  assign mem_mask    = mem_cs ? r_mask : '0;
  assign mem_addr    = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata   = r_wdata;

  // Access FSM: latch the request, wait for the memory or the timeout, retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_store <= 1'b0;
      r_f3    <= 3'b000;
      r_mask  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= addr;
            r_store <= is_store;
            r_f3    <= funct3;
            r_mask  <= f_mask(w_sz, addr[OFF_W-1:0]);
            r_wdata <= f_align(w_sz, wdata);
            r_cnt   <= '0;
            r_fault <= 1'b0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            if (!r_store) r_rdata <= f_extend(r_f3, w_lane);
            r_state <= S_RESP;
          end else if ((TIMEOUT != 0) && (r_cnt == TO_C)) begin
            r_fault <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a 32-bit instance (TIMEOUT=4) checked every cycle
// against a transaction-level timeline model, and a 64-bit instance exercised
// with directed vectors.
module tb_lsu_mem_ctrl;
  localparam int TO   = 4;
  localparam int NCYC = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance signals
  logic        req_valid, is_store, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, done, fault, mem_cs, mem_wr;
  logic [3:0]  fault_cause, mem_mask;
  logic [31:0] fault_addr, mem_addr, mem_wdata, rdata;

  // 64-bit instance signals
  logic        req_valid_64, is_store_64, mem_ready_64;
  logic [2:0]  funct3_64;
  logic [31:0] addr_64;
  logic [63:0] wdata_64, mem_rdata_64;
  logic        stall_64, done_64, fault_64, mem_cs_64, mem_wr_64;
  logic [3:0]  fault_cause_64;
  logic [7:0]  mem_mask_64;
  logic [31:0] fault_addr_64, mem_addr_64;
  logic [63:0] mem_wdata_64, rdata_64;

  lsu_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr), .mem_cs(mem_cs), .mem_wr(mem_wr),
    .mem_mask(mem_mask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  lsu_mem_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid_64), .is_store(is_store_64), .funct3(funct3_64),
    .addr(addr_64), .wdata(wdata_64), .stall(stall_64), .done(done_64), .rdata(rdata_64),
    .fault(fault_64), .fault_cause(fault_cause_64), .fault_addr(fault_addr_64),
    .mem_cs(mem_cs_64), .mem_wr(mem_wr_64), .mem_mask(mem_mask_64), .mem_addr(mem_addr_64),
    .mem_wdata(mem_wdata_64), .mem_rdata(mem_rdata_64), .mem_ready(mem_ready_64));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  int last_t, last_done;

  // expected per-cycle timeline of the 32-bit instance
  bit          e_stall[NCYC], e_done[NCYC], e_cs[NCYC], e_wr[NCYC], e_fault[NCYC], e_rchk[NCYC];
  logic [63:0] e_mask[NCYC], e_maddr[NCYC], e_wdata[NCYC], e_cause[NCYC], e_faddr[NCYC], e_rdata[NCYC];
  // observed values, for literal checks after a transaction
  bit          o_stall[NCYC], o_done[NCYC], o_cs[NCYC], o_fault[NCYC];
  logic [63:0] o_mask[NCYC], o_maddr[NCYC], o_wdata[NCYC], o_cause[NCYC], o_faddr[NCYC], o_rdata[NCYC];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= NCYC - 1) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d want<%0d", cyc, cyc, NCYC - 1);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_illegal(input logic [2:0] f3, input int w);
    return (f3 == 3'd7) || ((w == 32) && ((f3 == 3'd3) || (f3 == 3'd6)));
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [63:0] a);
    return (a % 64'(m_nbytes(f3))) != 64'd0;
  endfunction

  function automatic logic [63:0] m_mask(input logic [2:0] f3, input logic [63:0] a, input int nb);
    logic [63:0] m;
    int off, n;
    m = '0;
    off = int'(a % 64'(nb));
    n = m_nbytes(f3);
    for (int i = 0; i < n; i++) m[off + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_store(input logic [2:0] f3, input logic [63:0] wd, input int nb);
    logic [63:0] s;
    int n;
    s = '0;
    n = m_nbytes(f3);
    for (int j = 0; j < nb; j++) s[8*j +: 8] = wd[8*(j % n) +: 8];
    return s;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] a,
                                         input logic [63:0] mem, input int nb);
    logic [63:0] v;
    int off, n;
    v = '0;
    off = int'(a % 64'(nb));
    n = m_nbytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem[8*(off + i) +: 8];
    if (!f3[2] && v[8*n - 1])
      for (int i = n; i < nb; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic int cnt_stall(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(o_stall[i]);
    return c;
  endfunction

  function automatic int cnt_cs(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) c += int'(o_cs[i]);
    return c;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      chk("stall", 64'(stall), 64'(e_stall[cyc]));
      chk("done", 64'(done), 64'(e_done[cyc]));
      chk("fault", 64'(fault), 64'(e_fault[cyc]));
      chk("mem_cs", 64'(mem_cs), 64'(e_cs[cyc]));
      chk("mem_mask", 64'(mem_mask), e_mask[cyc]);
      if (e_cs[cyc]) begin
        chk("mem_wr", 64'(mem_wr), 64'(e_wr[cyc]));
        chk("mem_addr", 64'(mem_addr), e_maddr[cyc]);
        chk("mem_wdata", 64'(mem_wdata), e_wdata[cyc]);
      end
      if (e_done[cyc] && e_fault[cyc]) begin
        chk("fault_cause", 64'(fault_cause), e_cause[cyc]);
        chk("fault_addr", 64'(fault_addr), e_faddr[cyc]);
      end
      if (e_rchk[cyc]) chk("rdata", 64'(rdata), e_rdata[cyc]);
      o_stall[cyc] <= stall;
      o_done[cyc]  <= done;
      o_cs[cyc]    <= mem_cs;
      o_fault[cyc] <= fault;
      o_mask[cyc]  <= 64'(mem_mask);
      o_maddr[cyc] <= 64'(mem_addr);
      o_wdata[cyc] <= 64'(mem_wdata);
      o_cause[cyc] <= 64'(fault_cause);
      o_faddr[cyc] <= 64'(fault_addr);
      o_rdata[cyc] <= 64'(rdata);
    end
  end

  // One access on the 32-bit instance; k = cycles until mem_ready (<0: never).
  task automatic do32(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int k);
    int t, acc_n, r;
    bit ill, tmo;
    t = cyc;
    ill = m_illegal(f3, 32);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    if (ill || m_misal(f3, 64'(a))) begin
      e_done[t] = 1'b1; e_fault[t] = 1'b1; e_faddr[t] = 64'(a);
      e_cause[t] = ill ? (st ? 64'd7 : 64'd5) : (st ? 64'd6 : 64'd4);
      step();
      req_valid = 1'b0;
      last_t = t; last_done = t;
      return;
    end
    tmo = (k < 0) || (k > TO);
    acc_n = tmo ? TO + 1 : k + 1;
    r = t + 1 + acc_n;
    e_stall[t] = 1'b1;
    for (int n = 0; n < acc_n; n++) begin
      e_stall[t+1+n] = 1'b1;
      e_cs[t+1+n]    = 1'b1;
      e_wr[t+1+n]    = st;
      e_mask[t+1+n]  = m_mask(f3, 64'(a), 4);
      e_maddr[t+1+n] = 64'(a & ~32'h3);
      e_wdata[t+1+n] = m_store(f3, 64'(wd), 4);
    end
    e_done[r]  = 1'b1;
    e_fault[r] = tmo;
    e_cause[r] = st ? 64'd7 : 64'd5;
    e_faddr[r] = 64'(a);
    e_rchk[r]  = !st && !tmo;
    e_rdata[r] = m_load(f3, 64'(a), 64'(rd), 4);
    step();
    for (int n = 0; n < acc_n; n++) begin
      mem_ready = !tmo && (n == k);
      mem_rdata = mem_ready ? rd : ~rd;
      step();
    end
    mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    last_t = t; last_done = r;
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_stall"}, 64'(stall), 64'd0);
    chk({p, "_done"}, 64'(done), 64'd0);
    chk({p, "_fault"}, 64'(fault), 64'd0);
    chk({p, "_cause"}, 64'(fault_cause), 64'd0);
    chk({p, "_faddr"}, 64'(fault_addr), 64'd0);
    chk({p, "_rdata"}, 64'(rdata), 64'd0);
    chk({p, "_cs"}, 64'(mem_cs), 64'd0);
    chk({p, "_wr"}, 64'(mem_wr), 64'd0);
    chk({p, "_mask"}, 64'(mem_mask), 64'd0);
    chk({p, "_maddr"}, 64'(mem_addr), 64'd0);
    chk({p, "_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Access whose ACCESS phase is cut short by a reset pulse.
  task automatic do32_abort(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
    int t;
    t = cyc;
    e_stall[t]   = 1'b1;
    e_stall[t+1] = 1'b1;
    e_cs[t+1]    = 1'b1;
    e_wr[t+1]    = st;
    e_mask[t+1]  = m_mask(f3, 64'(a), 4);
    e_maddr[t+1] = 64'(a & ~32'h3);
    e_wdata[t+1] = m_store(f3, 64'(wd), 4);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    step();
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk_reset_outputs("abort");
    last_t = t;
  endtask

  // Directed access on the 64-bit instance with k=0.
  task automatic do64(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [63:0] wd, input logic [63:0] rd,
                      input logic [63:0] x_mask, input logic [63:0] x_data);
    req_valid_64 = 1'b1; is_store_64 = st; funct3_64 = f3; addr_64 = a; wdata_64 = wd;
    #1;
    chk("d64_stall_req", 64'(stall_64), 64'd1);
    step();
    mem_ready_64 = 1'b1; mem_rdata_64 = rd;
    #1;
    chk("d64_cs", 64'(mem_cs_64), 64'd1);
    chk("d64_wr", 64'(mem_wr_64), 64'(st));
    chk("d64_mask", 64'(mem_mask_64), x_mask);
    chk("d64_maddr", 64'(mem_addr_64), 64'(a & ~32'h7));
    if (st) chk("d64_wdata", mem_wdata_64, x_data);
    step();
    mem_ready_64 = 1'b0;
    #1;
    chk("d64_done", 64'(done_64), 64'd1);
    chk("d64_fault", 64'(fault_64), 64'd0);
    chk("d64_stall_resp", 64'(stall_64), 64'd0);
    if (!st) chk("d64_rdata", rdata_64, x_data);
    step();
    req_valid_64 = 1'b0;
  endtask

  task automatic do64_fault(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [63:0] x_cause);
    req_valid_64 = 1'b1; is_store_64 = st; funct3_64 = f3; addr_64 = a;
    #1;
    chk("d64f_done", 64'(done_64), 64'd1);
    chk("d64f_fault", 64'(fault_64), 64'd1);
    chk("d64f_cause", 64'(fault_cause_64), x_cause);
    chk("d64f_faddr", 64'(fault_addr_64), 64'(a));
    chk("d64f_stall", 64'(stall_64), 64'd0);
    step();
    req_valid_64 = 1'b0;
    #1;
    chk("d64f_cs", 64'(mem_cs_64), 64'd0);
  endtask

  int t1done;

  initial begin
    for (int i = 0; i < NCYC; i++) begin
      e_stall[i] = 1'b0; e_done[i] = 1'b0; e_cs[i] = 1'b0; e_wr[i] = 1'b0;
      e_fault[i] = 1'b0; e_rchk[i] = 1'b0;
      e_mask[i] = '0; e_maddr[i] = '0; e_wdata[i] = '0;
      e_cause[i] = '0; e_faddr[i] = '0; e_rdata[i] = '0;
    end
    rst = 1'b1;
    req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    req_valid_64 = 1'b0; is_store_64 = 1'b0; funct3_64 = 3'b000; addr_64 = '0;
    wdata_64 = '0; mem_rdata_64 = '0; mem_ready_64 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk_en = 1'b1;
    #1;
    chk_reset_outputs("reset");
    step();

    // LB, sign-extended top byte
    do32(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
    chk("lb_mask", o_mask[last_t+1], 64'h8);
    chk("lb_done_at_2", 64'(o_done[last_t+2]), 64'd1);
    chk("lb_rdata", o_rdata[last_t+2], 64'hFFFF_FF80);
    chk("lb_stall_cycles", 64'(cnt_stall(last_t, last_t+2)), 64'd2);

    // SH with k=3
    do32(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 3);
    for (int i = 1; i <= 4; i++) chk("sh_mask_held", o_mask[last_t+i], 64'hC);
    chk("sh_wdata", o_wdata[last_t+4], 64'hABCD_ABCD);
    chk("sh_maddr", o_maddr[last_t+1], 64'h200);
    chk("sh_stall_cycles", 64'(cnt_stall(last_t, last_t+5)), 64'd5);
    chk("sh_cs_off_resp", 64'(o_cs[last_t+5]), 64'd0);
    chk("sh_done", 64'(o_done[last_t+5]), 64'd1);

    // immediate faults
    do32(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
    chk("lw_mis_done", 64'(o_done[last_t]), 64'd1);
    chk("lw_mis_cause", o_cause[last_t], 64'd4);
    chk("lw_mis_faddr", o_faddr[last_t], 64'h101);
    chk("lw_mis_stall", 64'(o_stall[last_t]), 64'd0);
    chk("lw_mis_cs", 64'(o_cs[last_t]), 64'd0);
    do32(1'b1, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    chk("sw_mis_cause", o_cause[last_t], 64'd6);
    do32(1'b0, 3'b110, 32'h4, 32'h0, 32'h0, 0);
    chk("lwu32_cause", o_cause[last_t], 64'd5);
    do32(1'b1, 3'b111, 32'h0, 32'h0, 32'h0, 0);
    chk("f3_111_store_cause", o_cause[last_t], 64'd7);

    // store timeout, then a store answered in the last allowed cycle
    do32(1'b1, 3'b010, 32'h300, 32'h5555_AAAA, 32'h0, -1);
    chk("tmo_access_cycles", 64'(cnt_cs(last_t, last_t+6)), 64'd5);
    chk("tmo_done", 64'(o_done[last_t+6]), 64'd1);
    chk("tmo_fault", 64'(o_fault[last_t+6]), 64'd1);
    chk("tmo_cause", o_cause[last_t+6], 64'd7);
    do32(1'b1, 3'b010, 32'h304, 32'h0BAD_F00D, 32'h0, 4);
    chk("late_ready_done", 64'(o_done[last_t+6]), 64'd1);
    chk("late_ready_nofault", 64'(o_fault[last_t+6]), 64'd0);

    // further load/store shapes
    do32(1'b0, 3'b001, 32'h2, 32'h0, 32'h8001_0000, 1);
    chk("lh_rdata", o_rdata[last_done], 64'hFFFF_8001);
    do32(1'b0, 3'b101, 32'h2, 32'h0, 32'h8001_0000, 0);
    chk("lhu_rdata", o_rdata[last_done], 64'h0000_8001);
    do32(1'b0, 3'b100, 32'h1, 32'h0, 32'h0000_F000, 2);
    do32(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 0);
    do32(1'b1, 3'b000, 32'h1, 32'h0000_0012, 32'h0, 0);
    chk("sb_wdata", o_wdata[last_t+1], 64'h1212_1212);

    // back-to-back load then store, k=1
    do32(1'b0, 3'b010, 32'h10, 32'h0, 32'h1122_3344, 1);
    t1done = last_done;
    do32(1'b1, 3'b000, 32'h13, 32'h0000_005A, 32'h0, 1);
    chk("b2b_accept_stall", 64'(o_stall[t1done+1]), 64'd1);
    chk("b2b_second_cs", 64'(o_cs[t1done+2]), 64'd1);
    chk("b2b_second_mask", o_mask[t1done+2], 64'h8);

    // reset pulse during the second access's ACCESS phase
    do32(1'b0, 3'b010, 32'h20, 32'h0, 32'h7777_8888, 1);
    do32_abort(1'b1, 3'b010, 32'h24, 32'hCAFE_F00D);
    repeat (8) step();

    // 64-bit instance
    do64(1'b0, 3'b110, 32'h4, 64'h0, 64'h9000_0001_DEAD_BEEF, 64'hF0, 64'h0000_0000_9000_0001);
    do64(1'b0, 3'b010, 32'h4, 64'h0, 64'h9000_0001_DEAD_BEEF, 64'hF0, 64'hFFFF_FFFF_9000_0001);
    do64(1'b0, 3'b011, 32'h8, 64'h0, 64'h8877_6655_4433_2211, 64'hFF, 64'h8877_6655_4433_2211);
    do64(1'b1, 3'b011, 32'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 64'hFF, 64'h0123_4567_89AB_CDEF);
    do64(1'b1, 3'b000, 32'h5, 64'hAB, 64'h0, 64'h20, 64'hABAB_ABAB_ABAB_ABAB);
    do64_fault(1'b0, 3'b011, 32'h4, 64'd4);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
